// File: rtl/dma_mem_port_arbiter_if.sv
// Avalon-MM bundle for the two-master RAM port arbiter: both master ports plus the RAM side.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding system.
interface dma_mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m0_address;
    logic [DATA_W/8-1:0] m0_byteenable;
    logic                m0_read;
    logic                m0_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_readdatavalid;
    logic                m0_waitrequest;

    logic [ADDR_W-1:0]   m1_address;
    logic [DATA_W/8-1:0] m1_byteenable;
    logic                m1_read;
    logic                m1_write;
    logic [DATA_W-1:0]   m1_writedata;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_readdatavalid;
    logic                m1_waitrequest;

    logic [ADDR_W-1:0]   ram_address;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic                ram_chipselect;
    logic                ram_write;
    logic [DATA_W-1:0]   ram_writedata;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_readdata, m0_readdatavalid, m0_waitrequest,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_readdata, m1_readdatavalid, m1_waitrequest,
        output ram_address, ram_byteenable, ram_chipselect, ram_write,
        output ram_writedata, ram_clken,
        input  ram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_readdata, m0_readdatavalid, m0_waitrequest,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_readdata, m1_readdatavalid, m1_waitrequest,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write,
        input  ram_writedata, ram_clken,
        output ram_readdata
    );
endinterface

// File: rtl/dma_mem_port_arbiter.sv
// Two-master Avalon-MM arbiter sharing one single-port RAM (1-cycle read latency, tagged return).
// Define DMA_ARB_FIXED_PRIO_STARVE_EN for master-0 priority with a master-1 starvation guard.
module dma_mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    dma_mem_port_arbiter_if.slave    bus
);
    logic w_req0;
    logic w_req1;
    logic w_tieM0;
    logic w_grant0;
    logic w_grant1;
    logic w_rdAccept;

    logic r_lastGrant;
    logic r_rdV;
    logic r_rdId;
    logic r_ramClken;

    assign w_req0 = bus.m0_read | bus.m0_write;
    assign w_req1 = bus.m1_read | bus.m1_write;

`ifdef DMA_ARB_FIXED_PRIO_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starveCnt;

    assign w_tieM0 = (r_starveCnt != CNT_W'(STARVE_LIMIT));

    // Saturating wait counter for master 1; any grant or dropped request clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starveCnt <= '0;
        end else if (w_req1 && !w_grant1) begin
            if (r_starveCnt != CNT_W'(STARVE_LIMIT)) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end else begin
            r_starveCnt <= '0;
        end
    end
`else
    assign w_tieM0 = r_lastGrant;
`endif

    // No grant is issued while reset is held, which keeps chipselect/write low.
    assign w_grant0 = reset_n & w_req0 & (~w_req1 | w_tieM0);
    assign w_grant1 = reset_n & w_req1 & ~w_grant0;

    assign w_rdAccept = (w_grant0 & bus.m0_read & ~bus.m0_write)
                      | (w_grant1 & bus.m1_read & ~bus.m1_write);

    assign bus.ram_address    = w_grant1 ? bus.m1_address    : bus.m0_address;
    assign bus.ram_byteenable = w_grant1 ? bus.m1_byteenable : bus.m0_byteenable;
    assign bus.ram_writedata  = w_grant1 ? bus.m1_writedata  : bus.m0_writedata;
    assign bus.ram_write      = (w_grant0 & bus.m0_write) | (w_grant1 & bus.m1_write);
    assign bus.ram_chipselect = w_grant0 | w_grant1;
    assign bus.ram_clken      = r_ramClken;

    assign bus.m0_waitrequest = ~reset_n | (w_req0 & ~w_grant0);
    assign bus.m1_waitrequest = ~reset_n | (w_req1 & ~w_grant1);

    // A return landing while reset is low is dropped.
    assign bus.m0_readdatavalid = reset_n & r_rdV & ~r_rdId;
    assign bus.m1_readdatavalid = reset_n & r_rdV &  r_rdId;
    assign bus.m0_readdata      = bus.ram_readdata;
    assign bus.m1_readdata      = bus.ram_readdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lastGrant <= 1'b1;
            r_rdV       <= 1'b0;
            r_rdId      <= 1'b0;
            r_ramClken  <= 1'b0;
        end else begin
            r_ramClken <= 1'b1;
            if (w_grant0) begin
                r_lastGrant <= 1'b0;
            end else if (w_grant1) begin
                r_lastGrant <= 1'b1;
            end
            r_rdV <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdId <= w_grant1;
            end
        end
    end
endmodule

// File: doc/dma_mem_port_arbiter.md
Name: dma_mem_port_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the 1024x32 single-port on-chip RAM (dma_data_destination).
- Shares its one port between master 0 (msgDMA stream-to-memory write master) and master 1 (Nios II data master).
- Issues at most one access per clock. Returns read data with the RAM's fixed 1-cycle latency, tagged back to the issuing master.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- STARVE_LIMIT, 8, wait cycles before master 1 is force-granted. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  read data (shared bus)
- m0_readdatavalid  out  1  read data valid for master 0
- m0_waitrequest  out  1  master 0 stall
- m1_*  same set as m0_*, for master 1
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byteenable
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_clken  out  1  to RAM clken
- ram_readdata  in  DATA_W  from RAM readdata (unregistered q)

Behaviour:
- Request: req_x = mx_read | mx_write. If a master asserts read and write together, the write is performed and the read is dropped; no readdatavalid is returned for it.
- Grant (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: the master not recorded in last_grant wins.
- Transfer: the granted master's address, byteenable, writedata and write drive the ram_* ports. ram_chipselect = 1 whenever any grant is active, else 0. ram_write = 0 when there is no grant.
- Waitrequest: mx_waitrequest = ~reset_n | (req_x & ~grant_x). When idle and out of reset, waitrequest is 0.
- Acceptance: a transfer is accepted on any edge where grant_x = 1. last_grant <= x on each accepted transfer and holds when idle.
- Read return:
  - On an accepted read, register rd_v <= 1 and rd_id <= x; otherwise rd_v <= 0.
  - mx_readdatavalid = rd_v & (rd_id == x).
  - m0_readdata and m1_readdata both = ram_readdata.
  - Latency is exactly 1 cycle after acceptance. Back-to-back reads give one valid per cycle.
- Read-after-write: sequential in the single port. A read of an address written in the previous accepted cycle returns the new data; no bypass is needed.
- ram_clken: registered. It is 0 during reset and the cycle after, then 1.
- Reset (synchronous, reset_n = 0 sampled on clk):
  - last_grant <= 1, so master 0 wins the first tie.
  - rd_v <= 0, rd_id <= 0, ram_clken <= 0, starve_cnt <= 0.
  - During reset: both waitrequests = 1, ram_chipselect = 0, ram_write = 0.
- Reset mid-read: a read accepted in the cycle before reset asserts has its readdatavalid suppressed if reset is low at the return edge.
- Masters hold request signals stable while waitrequest = 1 (Avalon rule). The arbiter does not latch requests.

Optional Feature:
- Macro: DMA_ARB_FIXED_PRIO_STARVE_EN.
- Defined:
  - Master 0 has strict priority on ties.
  - A saturating counter starve_cnt increments each cycle master 1 requests and is not granted, and clears when master 1 is granted or stops requesting.
  - When starve_cnt == STARVE_LIMIT, master 1 wins the next tie.
- Undefined: pure round-robin as above; no counter logic is synthesized.

Test Plan:
- Reset then idle → both waitrequest = 1 during reset. Waitrequest = 0 and ram_clken = 1 from the second cycle after reset_n rises.
- m0 write addr 0x005 data 0xDEADBEEF be 0xF, then m1 read 0x005 → m1_readdatavalid = 1 exactly 1 cycle after acceptance, readdata 0xDEADBEEF, m0_readdatavalid stays 0.
- Both masters issue continuous reads at 0x010/0x020 for 8 cycles (round-robin build) → grants alternate m0, m1, m0, ... Each master gets 4 accepts with correctly tagged readdatavalid.
- m1 writes be = 4'b0010, data 0x0000AB00 to 0x3FF (top address), then reads 0x3FF → only byte 1 changed, no address wrap.
- Reset asserted the cycle after an m0 read is accepted → no m0_readdatavalid, and m0 wins the first tie after reset.
- DMA_ARB_FIXED_PRIO_STARVE_EN defined, STARVE_LIMIT = 8, both masters saturate → m0 granted for 8 cycles, m1 granted on the 9th, and the pattern repeats.
